// File: rtl/sw_pe_array_ctrl.sv
// Segment sequencer for the Smith-Waterman PE array: loads query segments, streams the target,
// spills/replays the last-PE boundary column and tracks the best score. Option: SW_ARRAY_POS_EN.
module sw_pe_array_ctrl #(
    parameter int NUM_PE     = 64,
    parameter int VEF_BIT    = 16,
    parameter int T_LEN_BIT  = 10,
    parameter int NUM_PE_LOG = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [T_LEN_BIT-1:0]     i_t_len,
    input  logic [VEF_BIT-1:0]       i_match,
    input  logic [VEF_BIT-1:0]       i_mismatch,
    input  logic [VEF_BIT-1:0]       i_minusAlpha,
    input  logic [VEF_BIT-1:0]       i_minusBeta,
    input  logic                     i_param_valid,
    output logic                     o_request_s,
    input  logic [NUM_PE*2-1:0]      i_s,
    input  logic [NUM_PE_LOG-1:0]    i_s_len,
    input  logic                     i_s_valid,
    input  logic                     i_s_last,
    output logic                     o_t_rd,
    output logic [T_LEN_BIT-1:0]     o_t_addr,
    input  logic [1:0]               i_t_data,
    output logic                     o_spill_rd,
    output logic [T_LEN_BIT-1:0]     o_spill_raddr,
    input  logic [2*VEF_BIT-1:0]     i_spill_rdata,
    output logic                     o_spill_wr,
    output logic [T_LEN_BIT-1:0]     o_spill_waddr,
    output logic [2*VEF_BIT-1:0]     o_spill_wdata,
    output logic                     o_pe_load,
    output logic [NUM_PE*2-1:0]      o_pe_s,
    output logic [NUM_PE_LOG-1:0]    o_pe_s_len,
    output logic [4*VEF_BIT-1:0]     o_pe_param,
    output logic [1:0]               o_pe_t,
    output logic [VEF_BIT-1:0]       o_pe_v_in,
    output logic [VEF_BIT-1:0]       o_pe_f_in,
    output logic                     o_pe_in_valid,
    input  logic [VEF_BIT-1:0]       i_pe_v_out,
    input  logic [VEF_BIT-1:0]       i_pe_f_out,
    input  logic [VEF_BIT-1:0]       i_pe_max,
    input  logic                     i_pe_out_valid,
`ifdef SW_ARRAY_POS_EN
    output logic [15:0]              o_max_seg,
    output logic [T_LEN_BIT-1:0]     o_max_col,
`endif
    output logic                     o_busy,
    output logic [VEF_BIT-1:0]       o_result,
    output logic                     o_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_S, S_RUN, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [T_LEN_BIT-1:0]    t_len_reg;
    logic [NUM_PE*2-1:0]     s_reg;
    logic [NUM_PE_LOG-1:0]   s_len_reg;
    logic                    s_last_reg;
    logic [15:0]             seg_reg;
    logic [T_LEN_BIT-1:0]    rd_ptr_reg;
    logic [T_LEN_BIT-1:0]    wr_ptr_reg;
    logic [VEF_BIT-1:0]      max_reg;
    logic                    load_reg;
    logic                    in_valid_reg;
    logic                    capture;
    logic [VEF_BIT-1:0]      param_in  [4];
    logic [VEF_BIT-1:0]      param_reg [4];

    assign param_in[0] = i_match;
    assign param_in[1] = i_mismatch;
    assign param_in[2] = i_minusAlpha;
    assign param_in[3] = i_minusBeta;

    // Parameter 0 (match) lands in the MSBs of o_pe_param.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_param
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    param_reg[gi] <= '0;
                end else if (state_reg == S_IDLE && i_param_valid) begin
                    param_reg[gi] <= param_in[gi];
                end
            end
            assign o_pe_param[(3-gi)*VEF_BIT +: VEF_BIT] = param_reg[gi];
        end
    endgenerate

    assign capture = i_pe_out_valid && (state_reg == S_RUN || state_reg == S_DRAIN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (i_start) state_next = (i_t_len == '0) ? S_DONE : S_LOAD_S;
            S_LOAD_S: if (i_s_valid) state_next = (i_s_len == '0) ? S_NEXT : S_RUN;
            S_RUN:    if (rd_ptr_reg == t_len_reg - T_LEN_BIT'(1)) state_next = S_DRAIN;
            S_DRAIN:  if (wr_ptr_reg == t_len_reg) state_next = S_NEXT;
            S_NEXT:   state_next = s_last_reg ? S_DONE : S_LOAD_S;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

`ifdef SW_ARRAY_POS_EN
    logic [15:0]          max_seg_reg;
    logic [T_LEN_BIT-1:0] max_col_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_seg_reg <= '0;
            max_col_reg <= '0;
        end else if (state_reg == S_IDLE && i_start) begin
            max_seg_reg <= '0;
            max_col_reg <= '0;
        end else if (capture && i_pe_max > max_reg) begin
            max_seg_reg <= seg_reg;
            max_col_reg <= wr_ptr_reg;
        end
    end

    assign o_max_seg = max_seg_reg;
    assign o_max_col = max_col_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            t_len_reg    <= '0;
            s_reg        <= '0;
            s_len_reg    <= '0;
            s_last_reg   <= 1'b0;
            seg_reg      <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            max_reg      <= '0;
            load_reg     <= 1'b0;
            in_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            load_reg     <= 1'b0;
            in_valid_reg <= (state_reg == S_RUN);
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        t_len_reg  <= i_t_len;
                        max_reg    <= '0;
                        seg_reg    <= '0;
                        rd_ptr_reg <= '0;
                        wr_ptr_reg <= '0;
                    end
                end
                S_LOAD_S: begin
                    if (i_s_valid) begin
                        s_reg      <= i_s;
                        s_len_reg  <= i_s_len;
                        s_last_reg <= i_s_last;
                        load_reg   <= (i_s_len != '0);
                    end
                end
                S_RUN: rd_ptr_reg <= rd_ptr_reg + T_LEN_BIT'(1);
                S_NEXT: begin
                    if (!s_last_reg) begin
                        seg_reg    <= seg_reg + 16'd1;
                        rd_ptr_reg <= '0;
                        wr_ptr_reg <= '0;
                    end
                end
                default: ;
            endcase
            // Column outputs arrive in order, so wr_ptr doubles as the drained-column count.
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + T_LEN_BIT'(1);
                if (i_pe_max > max_reg) max_reg <= i_pe_max;
            end
        end
    end

    assign o_busy        = (state_reg != S_IDLE);
    assign o_request_s   = (state_reg == S_LOAD_S);
    assign o_t_rd        = (state_reg == S_RUN);
    assign o_t_addr      = o_t_rd ? rd_ptr_reg : '0;
    assign o_spill_rd    = (state_reg == S_RUN) && (seg_reg != '0);
    assign o_spill_raddr = o_spill_rd ? rd_ptr_reg : '0;
    // The final segment's boundary column is never replayed, so it is not stored.
    assign o_spill_wr    = capture && !s_last_reg;
    assign o_spill_waddr = o_spill_wr ? wr_ptr_reg : '0;
    assign o_spill_wdata = o_spill_wr ? {i_pe_v_out, i_pe_f_out} : '0;
    assign o_pe_load     = load_reg;
    assign o_pe_s        = s_reg;
    assign o_pe_s_len    = s_len_reg;
    assign o_pe_in_valid = in_valid_reg;
    assign o_pe_t        = in_valid_reg ? i_t_data : 2'b00;
    assign o_pe_v_in     = (in_valid_reg && seg_reg != '0) ? i_spill_rdata[2*VEF_BIT-1:VEF_BIT] : '0;
    assign o_pe_f_in     = (in_valid_reg && seg_reg != '0) ? i_spill_rdata[VEF_BIT-1:0] : '0;
    assign o_result      = max_reg;
    assign o_valid       = (state_reg == S_DONE);

endmodule

// File: tb/tb_sw_pe_array_ctrl.sv
// Bench for sw_pe_array_ctrl: T buffer, spill SRAM and a 2-cycle PE array model around the DUT,
// with scoreboards for the PE input stream, load pulses and spill writes.
module tb_sw_pe_array_ctrl;
    localparam int NP = 4, VB = 16, TB = 10, NPL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            i_start = 0, i_param_valid = 0, i_s_valid = 0, i_s_last = 0;
    logic [TB-1:0]   i_t_len = '0;
    logic [VB-1:0]   i_match = '0, i_mismatch = '0, i_minusAlpha = '0, i_minusBeta = '0;
    logic [NP*2-1:0] i_s = '0;
    logic [NPL-1:0]  i_s_len = '0;
    logic [1:0]      i_t_data;
    logic [2*VB-1:0] i_spill_rdata;
    logic [VB-1:0]   i_pe_v_out, i_pe_f_out, i_pe_max;
    logic            i_pe_out_valid;
    logic            o_request_s, o_t_rd, o_spill_rd, o_spill_wr, o_pe_load, o_pe_in_valid;
    logic            o_busy, o_valid;
    logic [TB-1:0]   o_t_addr, o_spill_raddr, o_spill_waddr;
    logic [2*VB-1:0] o_spill_wdata;
    logic [NP*2-1:0] o_pe_s;
    logic [NPL-1:0]  o_pe_s_len;
    logic [4*VB-1:0] o_pe_param;
    logic [1:0]      o_pe_t;
    logic [VB-1:0]   o_pe_v_in, o_pe_f_in, o_result;
`ifdef SW_ARRAY_POS_EN
    logic [15:0]     o_max_seg;
    logic [TB-1:0]   o_max_col;
`endif

    sw_pe_array_ctrl #(.NUM_PE(NP), .VEF_BIT(VB), .T_LEN_BIT(TB), .NUM_PE_LOG(NPL)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_t_len(i_t_len),
        .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minusAlpha),
        .i_minusBeta(i_minusBeta), .i_param_valid(i_param_valid),
        .o_request_s(o_request_s), .i_s(i_s), .i_s_len(i_s_len), .i_s_valid(i_s_valid),
        .i_s_last(i_s_last), .o_t_rd(o_t_rd), .o_t_addr(o_t_addr), .i_t_data(i_t_data),
        .o_spill_rd(o_spill_rd), .o_spill_raddr(o_spill_raddr), .i_spill_rdata(i_spill_rdata),
        .o_spill_wr(o_spill_wr), .o_spill_waddr(o_spill_waddr), .o_spill_wdata(o_spill_wdata),
        .o_pe_load(o_pe_load), .o_pe_s(o_pe_s), .o_pe_s_len(o_pe_s_len), .o_pe_param(o_pe_param),
        .o_pe_t(o_pe_t), .o_pe_v_in(o_pe_v_in), .o_pe_f_in(o_pe_f_in),
        .o_pe_in_valid(o_pe_in_valid), .i_pe_v_out(i_pe_v_out), .i_pe_f_out(i_pe_f_out),
        .i_pe_max(i_pe_max), .i_pe_out_valid(i_pe_out_valid),
`ifdef SW_ARRAY_POS_EN
        .o_max_seg(o_max_seg), .o_max_col(o_max_col),
`endif
        .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] v_of(input int seg, input int col);
        return 16'(10 + col + seg * 100);
    endfunction
    function automatic logic [15:0] f_of(input int seg, input int col);
        return 16'(500 + col + seg * 100);
    endfunction
    // mode 0: 3,9,9,2 repeating; mode 1: rising; mode 2: falling from 50
    function automatic logic [15:0] max_of(input int mode, input int seg, input int col);
        int r;
        case (mode)
            0: case (col % 4) 0: r = 3; 1: r = 9; 2: r = 9; default: r = 2; endcase
            1: r = col + seg * 10;
            default: r = 50 - col - seg;
        endcase
        return 16'(r);
    endfunction

    // T buffer and spill SRAM models, 1-cycle read latency
    logic [1:0]      tmem [1024];
    logic [2*VB-1:0] smem [1024];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_t_data      <= '0;
            i_spill_rdata <= '0;
        end else begin
            if (o_t_rd) i_t_data <= tmem[o_t_addr];
            if (o_spill_rd) i_spill_rdata <= smem[o_spill_raddr];
            if (o_spill_wr) smem[o_spill_waddr] <= o_spill_wdata;
        end
    end

    // PE array model: each input column reappears at the last PE two cycles later
    int  cur_mode = 0, cur_seg = 0;
    bit  cur_last = 0;
    logic pv0, pv1;
    int  pc0, pc1, ps0, ps1, colcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv0 <= 0; pv1 <= 0; pc0 <= 0; pc1 <= 0; ps0 <= 0; ps1 <= 0; colcnt <= 0;
        end else begin
            pv0 <= o_pe_in_valid; pv1 <= pv0;
            pc0 <= colcnt; pc1 <= pc0;
            ps0 <= cur_seg; ps1 <= ps0;
            if (o_pe_load) colcnt <= 0;
            else if (o_pe_in_valid) colcnt <= colcnt + 1;
        end
    end
    assign i_pe_out_valid = pv1;
    assign i_pe_v_out = pv1 ? v_of(ps1, pc1) : '0;
    assign i_pe_f_out = pv1 ? f_of(ps1, pc1) : '0;
    assign i_pe_max   = pv1 ? max_of(cur_mode, ps1, pc1) : '0;

    // Scoreboards and monitor (sampled on the falling edge)
    logic [33:0]          exp_in_q [$];
    logic [NP*2+NPL-1:0]  exp_load_q [$];
    logic [TB+2*VB-1:0]   exp_wr_q [$];
    int exp_addr = 0, t_rd_cnt = 0, spill_rd_cnt = 0, req_cnt = 0, valid_cnt = 0;
    logic req_prev = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_request_s && !req_prev) req_cnt++;
            req_prev = o_request_s;
            if (o_valid) valid_cnt++;
            if (o_pe_load) begin
                if (exp_load_q.size() == 0) check("unexpected_load", 1, 0);
                else check("load_s", {o_pe_s, o_pe_s_len}, exp_load_q.pop_front());
            end
            if (o_spill_rd) begin
                spill_rd_cnt++;
                check("spill_raddr", o_spill_raddr, exp_addr);
            end
            if (o_t_rd) begin
                t_rd_cnt++;
                check("t_addr", o_t_addr, exp_addr);
                exp_addr++;
            end
            if (o_pe_in_valid) begin
                if (exp_in_q.size() == 0) check("unexpected_in_valid", 1, 0);
                else check("pe_in", {o_pe_t, o_pe_v_in, o_pe_f_in}, exp_in_q.pop_front());
            end
            if (i_pe_out_valid && !cur_last)
                exp_wr_q.push_back({TB'(pc1), i_pe_v_out, i_pe_f_out});
            if (o_spill_wr) begin
                if (exp_wr_q.size() == 0) check("unexpected_spill_wr", 1, 0);
                else check("spill_wr", {o_spill_waddr, o_spill_wdata}, exp_wr_q.pop_front());
            end
        end else begin
            req_prev = 0;
        end
    end

    task automatic run_job(input int t_len, input int nseg, input int mode, input int exp_res,
                           input int exp_seg, input int exp_col, input bit glitch, input bit abort);
        int to, vcnt0, slen;
        logic [NP*2-1:0] sv;
        logic [15:0] vv, ff;
        cur_mode = mode; t_rd_cnt = 0; spill_rd_cnt = 0; req_cnt = 0;
        vcnt0 = valid_cnt;
        @(posedge clk); #1;
        i_t_len = TB'(t_len); i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        for (int k = 0; k < nseg; k++) begin
            to = 0;
            do begin @(negedge clk); to++; end while (!o_request_s && to < 500);
            if (!o_request_s) begin check("request_timeout", 0, 1); return; end
            sv = NP*2'($urandom);
            slen = (k == nseg - 1 && nseg > 1) ? 2 : NP;
            exp_load_q.push_back({sv, NPL'(slen)});
            for (int j = 0; j < t_len; j++) begin
                vv = (k == 0) ? 16'd0 : v_of(k - 1, j);
                ff = (k == 0) ? 16'd0 : f_of(k - 1, j);
                exp_in_q.push_back({tmem[j], vv, ff});
            end
            cur_seg = k; cur_last = (k == nseg - 1); exp_addr = 0;
            i_s = sv; i_s_len = NPL'(slen); i_s_last = cur_last; i_s_valid = 1;
            @(posedge clk); #1;
            i_s_valid = 0; i_s_last = 0;
            if (glitch && k == 0) begin
                i_start = 1; i_param_valid = 1;
                i_match = 16'd77; i_mismatch = 16'd66; i_minusAlpha = 16'd55; i_minusBeta = 16'd44;
                @(posedge clk); #1;
                i_start = 0; i_param_valid = 0;
            end
            if (abort && k == 1) begin
                repeat (3) @(posedge clk);
                #1 rst_n = 0;
                #1;
                check("reset_outputs_zero", 64'(|{o_busy, o_valid, o_result, o_request_s, o_t_rd,
                      o_t_addr, o_spill_rd, o_spill_raddr, o_spill_wr, o_spill_waddr, o_spill_wdata,
                      o_pe_load, o_pe_s, o_pe_s_len, o_pe_param, o_pe_t, o_pe_v_in, o_pe_f_in,
                      o_pe_in_valid}), 0);
                exp_in_q.delete(); exp_load_q.delete(); exp_wr_q.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                repeat (8) @(negedge clk);
                check("abort_no_valid", valid_cnt - vcnt0, 0);
                check("abort_idle", o_busy, 0);
                $display("job t_len=%0d nseg=%0d aborted by reset", t_len, nseg);
                return;
            end
        end
        to = 0;
        do begin @(negedge clk); to++; end while (!o_valid && to < 2000);
        check("valid_seen", o_valid, 1);
        check("result", o_result, exp_res);
`ifdef SW_ARRAY_POS_EN
        check("max_seg", o_max_seg, exp_seg);
        check("max_col", o_max_col, exp_col);
`endif
        repeat (10) @(negedge clk);
        check("one_valid", valid_cnt - vcnt0, 1);
        check("result_hold", o_result, exp_res);
        check("t_rd_count", t_rd_cnt, t_len * nseg);
        check("spill_rd_count", spill_rd_cnt, (nseg > 0) ? t_len * (nseg - 1) : 0);
        check("request_count", req_cnt, nseg);
        check("in_q_empty", exp_in_q.size(), 0);
        check("wr_q_empty", exp_wr_q.size(), 0);
        $display("job t_len=%0d nseg=%0d mode=%0d result=%0d (want %0d)",
                 t_len, nseg, mode, o_result, exp_res);
    endtask

    typedef struct {
        int t_len; int nseg; int mode; int exp_res; int exp_seg; int exp_col; bit glitch;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 0, 1,  0, 0, 0, 0};
        vecs[1] = '{8, 1, 1,  7, 0, 7, 1};
        vecs[2] = '{5, 2, 1, 14, 1, 4, 0};
        vecs[3] = '{4, 1, 0,  9, 0, 1, 0};
        vecs[4] = '{6, 3, 2, 50, 0, 0, 0};
        vecs[5] = '{3, 2, 0,  9, 0, 1, 0};
        for (int j = 0; j < 1024; j++) tmem[j] = 2'($urandom);

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("reset_busy", o_busy, 0);
        check("reset_valid", o_valid, 0);
        check("reset_result", o_result, 0);
        check("reset_param", o_pe_param, 0);

        @(posedge clk); #1;
        i_match = 16'd5; i_mismatch = 16'd3; i_minusAlpha = 16'd2; i_minusBeta = 16'd1;
        i_param_valid = 1;
        @(posedge clk); #1;
        i_param_valid = 0;
        check("param_latch", o_pe_param, {16'd5, 16'd3, 16'd2, 16'd1});

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].t_len, vecs[v].nseg, vecs[v].mode, vecs[v].exp_res,
                    vecs[v].exp_seg, vecs[v].exp_col, vecs[v].glitch, 0);
        check("param_unchanged", o_pe_param, {16'd5, 16'd3, 16'd2, 16'd1});

        run_job(6, 2, 1, 0, 0, 0, 0, 1);
        check("reset_result_cleared", o_result, 0);
        run_job(vecs[2].t_len, vecs[2].nseg, vecs[2].mode, vecs[2].exp_res,
                vecs[2].exp_seg, vecs[2].exp_col, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
